// File: rtl/md5_pipe_scheduler.sv
// md5_pipe_scheduler: round-robin issue of single-block MD5 requests into one shared
// pipelined core. A tag line follows every block through the core so that each digest
// comes back labelled with the requester that issued it.
// Optional build macro: MD5_SCHED_STATS_EN adds per-requester issue/done counters.
module md5_pipe_scheduler #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned PIPE_LAT = 64,
   parameter int unsigned ID_W     = 2
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   input  logic [NUM_REQ*512-1:0] i_req_data,
   output logic [NUM_REQ-1:0]     o_req_ready,
   input  logic                   i_drain,
   output logic                   o_core_start,
   output logic [511:0]           o_core_data,
   output logic                   o_core_last512,
   input  logic                   i_core_done,
   input  logic [127:0]           i_core_digest,
   output logic                   o_rsp_valid,
   output logic [ID_W-1:0]        o_rsp_id,
   output logic [127:0]           o_rsp_digest,
   output logic                   o_busy,
   output logic                   o_idle,
   output logic                   o_err
`ifdef MD5_SCHED_STATS_EN
   ,
   input  logic [ID_W-1:0]        i_stat_sel,
   output logic [31:0]            o_stat_issued,
   output logic [31:0]            o_stat_done
`endif
);

   localparam int unsigned CntW = $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                       state_q;
   logic [ID_W-1:0]              ptr_q;
   logic                         grant_any;
   logic [ID_W-1:0]              grant_id;
   logic [NUM_REQ-1:0]           grant_oh;
   logic [511:0]                 grant_data;
   int unsigned                  arb_idx;
   logic [ID_W-1:0]              issue_id_q;
   logic [PIPE_LAT-1:0]          tag_v_q;
   logic [PIPE_LAT-1:0][ID_W-1:0] tag_id_q;
   logic                         tag_out_v;
   logic [ID_W-1:0]              tag_out_id;
   logic [CntW-1:0]              cnt_q;
   logic [CntW-1:0]              cnt_d;
   logic [CntW-1:0]              flush_q;
   logic                         stale_done;

   // Every block is a complete single-block message.
   assign o_core_last512 = 1'b1;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      grant_oh  = '0;
      arb_idx   = 0;
      if ((state_q == StIdle || state_q == StRun) && !i_drain) begin
         for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            arb_idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!grant_any && i_req_valid[arb_idx]) begin
               grant_any = 1'b1;
               grant_id  = arb_idx[ID_W-1:0];
               grant_oh  = NUM_REQ'(1) << arb_idx;
            end
         end
      end
   end

   assign o_req_ready = grant_oh;
   assign grant_data  = i_req_data[32'(grant_id) * 512 +: 512];

   // Issue register: one block per granted cycle, data holds otherwise.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_core_start <= 1'b0;
         o_core_data  <= '0;
         issue_id_q   <= '0;
      end else begin
         o_core_start <= grant_any;
         if (grant_any) begin
            o_core_data <= grant_data;
            issue_id_q  <= grant_id;
         end
      end
   end

   // Tag line: stage PIPE_LAT-1 lines up with the core's done for the same block.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         tag_v_q  <= '0;
         tag_id_q <= '0;
      end else begin
         tag_v_q  <= {tag_v_q[PIPE_LAT-2:0], o_core_start};
         tag_id_q <= {tag_id_q[PIPE_LAT-2:0], issue_id_q};
      end
   end

   assign tag_out_v  = tag_v_q[PIPE_LAT-1];
   assign tag_out_id = tag_id_q[PIPE_LAT-1];

   // Outstanding count tracks valid tag-line entries, so it never exceeds PIPE_LAT.
   always_comb begin
      cnt_d = cnt_q;
      if (o_core_start && !tag_out_v) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!o_core_start && tag_out_v) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // Outstanding counter register.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // After a reset the core may still complete blocks whose tags were discarded;
   // untagged dones are tolerated for one core latency.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         flush_q <= CntW'(PIPE_LAT);
      end else if (flush_q != '0) begin
         flush_q <= flush_q - CntW'(1);
      end
   end

   assign stale_done = (flush_q != '0) && !tag_out_v;

   // Response capture and sticky done/tag mismatch flag.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_rsp_valid  <= 1'b0;
         o_rsp_id     <= '0;
         o_rsp_digest <= '0;
         o_err        <= 1'b0;
      end else begin
         o_rsp_valid  <= tag_out_v & i_core_done;
         o_rsp_id     <= tag_out_id;
         o_rsp_digest <= i_core_digest;
         if ((tag_out_v != i_core_done) && !stale_done) begin
            o_err <= 1'b1;
         end
      end
   end

   // Control FSM with RR pointer and registered busy/idle status.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= StIdle;
         ptr_q   <= ID_W'(NUM_REQ - 1);
         o_busy  <= 1'b0;
         o_idle  <= 1'b1;
      end else begin
         if (grant_any) begin
            ptr_q <= grant_id;
         end
         o_busy <= (cnt_d != '0) || grant_any;
         unique case (state_q)
            StIdle: begin
               if (grant_any) begin
                  state_q <= StRun;
                  o_idle  <= 1'b0;
               end
            end
            StRun: begin
               if (i_drain) begin
                  state_q <= StDrain;
                  o_idle  <= 1'b0;
               end else if (cnt_d == '0 && !grant_any) begin
                  state_q <= StIdle;
                  o_idle  <= 1'b1;
               end
            end
            StDrain: begin
               if (!i_drain) begin
                  if (cnt_d == '0) begin
                     state_q <= StIdle;
                     o_idle  <= 1'b1;
                  end else begin
                     state_q <= StRun;
                     o_idle  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               o_idle  <= 1'b1;
            end
         endcase
      end
   end

`ifdef MD5_SCHED_STATS_EN
   logic [31:0] stat_iss_q  [NUM_REQ];
   logic [31:0] stat_done_q [NUM_REQ];

   // Per-requester wrapping counters and registered view of the selected requester.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            stat_iss_q[k]  <= '0;
            stat_done_q[k] <= '0;
         end
         o_stat_issued <= '0;
         o_stat_done   <= '0;
      end else begin
         if (grant_any) begin
            stat_iss_q[grant_id] <= stat_iss_q[grant_id] + 32'd1;
         end
         if (o_rsp_valid) begin
            stat_done_q[o_rsp_id] <= stat_done_q[o_rsp_id] + 32'd1;
         end
         if (32'(i_stat_sel) < NUM_REQ) begin
            o_stat_issued <= stat_iss_q[i_stat_sel];
            o_stat_done   <= stat_done_q[i_stat_sel];
         end else begin
            o_stat_issued <= '0;
            o_stat_done   <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_md5_pipe_scheduler.sv
// Bench for md5_pipe_scheduler: random and directed traffic, a behavioural core model
// with fixed latency, and a scoreboard checked by an independent response monitor.
module tb_md5_pipe_scheduler;

   localparam int unsigned NUM_REQ  = 4;
   localparam int unsigned PIPE_LAT = 64;
   localparam int unsigned ID_W     = 2;

   localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 64'h18000000_00000000};
   localparam logic [511:0] BLK_A   = {32'h61800000, 416'h0, 64'h08000000_00000000};
   localparam logic [511:0] BLK_AB  = {32'h61628000, 416'h0, 64'h10000000_00000000};

   logic                   i_clk = 1'b0;
   logic                   i_reset = 1'b0;
   logic [NUM_REQ-1:0]     i_req_valid = '0;
   logic [NUM_REQ*512-1:0] i_req_data = '0;
   logic [NUM_REQ-1:0]     o_req_ready;
   logic                   i_drain = 1'b0;
   logic                   o_core_start;
   logic [511:0]           o_core_data;
   logic                   o_core_last512;
   logic                   i_core_done = 1'b0;
   logic [127:0]           i_core_digest = '0;
   logic                   o_rsp_valid;
   logic [ID_W-1:0]        o_rsp_id;
   logic [127:0]           o_rsp_digest;
   logic                   o_busy;
   logic                   o_idle;
   logic                   o_err;
`ifdef MD5_SCHED_STATS_EN
   logic [ID_W-1:0]        i_stat_sel = '0;
   logic [31:0]            o_stat_issued;
   logic [31:0]            o_stat_done;
`endif

   md5_pipe_scheduler #(
      .NUM_REQ (NUM_REQ),
      .PIPE_LAT(PIPE_LAT),
      .ID_W    (ID_W)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_req_valid   (i_req_valid),
      .i_req_data    (i_req_data),
      .o_req_ready   (o_req_ready),
      .i_drain       (i_drain),
      .o_core_start  (o_core_start),
      .o_core_data   (o_core_data),
      .o_core_last512(o_core_last512),
      .i_core_done   (i_core_done),
      .i_core_digest (i_core_digest),
      .o_rsp_valid   (o_rsp_valid),
      .o_rsp_id      (o_rsp_id),
      .o_rsp_digest  (o_rsp_digest),
      .o_busy        (o_busy),
      .o_idle        (o_idle),
      .o_err         (o_err)
`ifdef MD5_SCHED_STATS_EN
      ,
      .i_stat_sel    (i_stat_sel),
      .o_stat_issued (o_stat_issued),
      .o_stat_done   (o_stat_done)
`endif
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Core behaviour: known test vectors return real MD5, anything else a fixed fold.
   function automatic logic [127:0] core_fn(input logic [511:0] d);
      if (d == BLK_ABC) return 128'h900150983cd24fb0d6963f7d28e17f72;
      if (d == BLK_A)   return 128'h0cc175b9c0f1b6a831c399e269772661;
      if (d == BLK_AB)  return 128'h187ef4436122d1cc2f40dc2b92f0eba0;
      return d[127:0] ^ d[255:128] ^ d[383:256] ^ d[511:384] ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   typedef struct {
      int           due;
      logic [511:0] data;
   } core_ent_t;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [127:0]    dig;
      int              cyc;
   } exp_t;

   core_ent_t core_q[$];
   exp_t      exp_q[$];
   logic      spurious = 1'b0;

   // Core model: fixed PIPE_LAT from start cycle to done; not reset with the scheduler.
   always @(negedge i_clk) begin
      core_ent_t ent;
      i_core_done = 1'b0;
      if (core_q.size() != 0 && core_q[0].due == cyc) begin
         i_core_done   = 1'b1;
         i_core_digest = core_fn(core_q[0].data);
         void'(core_q.pop_front());
      end
      if (spurious) begin
         i_core_done   = 1'b1;
         i_core_digest = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      end
      if (o_core_start === 1'b1) begin
         ent.due  = cyc + PIPE_LAT;
         ent.data = o_core_data;
         core_q.push_back(ent);
      end
   end

   // Response monitor: every result must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      exp_t e;
      #1;
      if (o_rsp_valid !== 1'b0) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", {511'b0, o_rsp_valid}, 512'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", o_rsp_id, e.id);
            check("rsp_digest", o_rsp_digest, e.dig);
            check("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   logic [511:0] rd [NUM_REQ];
   int           last_gnt = NUM_REQ - 1;
   bit           prev_fire = 0;
   bit           prev_dr = 0;
   bit           have_fire = 0;
   int           last_fire_cyc = 0;
   logic [511:0] prev_data = '0;

   // One clock of stimulus plus grant/issue/busy checks against the reference rules.
   task automatic step(input logic [NUM_REQ-1:0] v_in, input logic dr);
      logic [NUM_REQ-1:0] v;
      logic [NUM_REQ-1:0] exp_oh;
      int                 gid;
      exp_t               e;
      v = prev_dr ? '0 : v_in;
      @(negedge i_clk);
      i_req_valid = v;
      i_drain     = dr;
      for (int k = 0; k < NUM_REQ; k++) i_req_data[k*512 +: 512] = rd[k];
      #2;
      check("core_start", o_core_start, prev_fire);
      if (prev_fire) check("core_data", o_core_data, prev_data);
      if (have_fire && cyc == last_fire_cyc + PIPE_LAT + 1) check("busy_before_drop", o_busy, 1'b1);
      if (have_fire && cyc == last_fire_cyc + PIPE_LAT + 2) check("busy_drop", o_busy, 1'b0);
      exp_oh = '0;
      gid    = -1;
      if (!dr) begin
         for (int i = 1; i <= NUM_REQ; i++) begin
            int k;
            k = (last_gnt + i) % NUM_REQ;
            if (gid < 0 && v[k]) gid = k;
         end
      end
      if (gid >= 0) exp_oh[gid] = 1'b1;
      check("req_ready", o_req_ready, exp_oh);
      prev_fire = (gid >= 0);
      prev_dr   = dr;
      if (gid >= 0) begin
         prev_data     = rd[gid];
         last_gnt      = gid;
         have_fire     = 1;
         last_fire_cyc = cyc;
         e.id  = gid[ID_W-1:0];
         e.dig = core_fn(rd[gid]);
         e.cyc = cyc + PIPE_LAT + 2;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset(input int n, input bit chk);
      @(negedge i_clk);
      i_reset     = 1'b0;
      i_req_valid = '0;
      i_drain     = 1'b0;
      exp_q.delete();
      last_gnt  = NUM_REQ - 1;
      prev_fire = 0;
      prev_dr   = 0;
      have_fire = 0;
      repeat (n) begin
         @(posedge i_clk);
         #2;
      end
      if (chk) begin
         check("rst_ready", o_req_ready, '0);
         check("rst_core_start", o_core_start, 1'b0);
         check("rst_core_data", o_core_data, '0);
         check("rst_rsp_valid", o_rsp_valid, 1'b0);
         check("rst_rsp_id", o_rsp_id, '0);
         check("rst_rsp_digest", o_rsp_digest, '0);
         check("rst_busy", o_busy, 1'b0);
         check("rst_idle", o_idle, 1'b1);
         check("rst_err", o_err, 1'b0);
      end
      @(negedge i_clk);
      i_reset = 1'b1;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step('0, 1'b0);
      check("all_responses", exp_q.size(), 0);
      repeat (3) step('0, 1'b0);
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] d;
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      return d;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog cycles=%0d required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < NUM_REQ; k++) rd[k] = '0;
      do_reset(2, 1'b1);
      check("last512_tied", o_core_last512, 1'b1);

      // Basic single "abc" block from requester 0.
      rd[0] = BLK_ABC;
      step(4'b0001, 1'b0);
      step('0, 1'b0);
      check("busy_inflight", o_busy, 1'b1);
      check("idle_inflight", o_idle, 1'b0);
      wait_empty();
      check("idle_after_basic", o_idle, 1'b1);
      check("busy_after_basic", o_busy, 1'b0);

      // Round-robin with all four requesters continuously valid.
      do_reset(1, 1'b0);
      rd[0] = BLK_A;
      rd[1] = BLK_AB;
      rd[2] = BLK_ABC;
      rd[3] = BLK_A;
      repeat (8) step(4'b1111, 1'b0);
      wait_empty();
`ifdef MD5_SCHED_STATS_EN
      i_stat_sel = 2'd2;
      step('0, 1'b0);
      step('0, 1'b0);
      check("stat_issued", o_stat_issued, 32'd2);
      check("stat_done", o_stat_done, 32'd2);
`endif

      // Randomised traffic with occasional drain bursts.
      begin
         int drain_left;
         drain_left = 0;
         for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_REQ; k++) rd[k] = rand_blk();
            if (drain_left == 0 && $urandom_range(0, 29) == 0) drain_left = $urandom_range(1, 6);
            step(NUM_REQ'($urandom), drain_left != 0);
            if (drain_left != 0) drain_left--;
         end
      end
      wait_empty();

      // Drain with ten blocks outstanding.
      for (int n = 0; n < 10; n++) begin
         rd[0] = rand_blk();
         step(4'b0001, 1'b0);
      end
      repeat (80) step(4'b1111, 1'b1);
      check("drain_all_rsp", exp_q.size(), 0);
      check("drain_not_idle", o_idle, 1'b0);
      check("drain_busy_clear", o_busy, 1'b0);
      step('0, 1'b0);
      step('0, 1'b0);
      check("idle_after_drain", o_idle, 1'b1);

      // Reset pulse with twenty blocks in flight: none of them may come back.
      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < NUM_REQ; k++) rd[k] = rand_blk();
         step(4'b1111, 1'b0);
      end
      do_reset(1, 1'b0);
      repeat (90) step('0, 1'b0);
      check("midrst_err", o_err, 1'b0);
      check("midrst_busy", o_busy, 1'b0);
      check("midrst_idle", o_idle, 1'b1);

      // Spurious done with no tag sets the sticky error.
      step('0, 1'b0);
      spurious = 1'b1;
      step('0, 1'b0);
      spurious = 1'b0;
      step('0, 1'b0);
      check("err_set", o_err, 1'b1);
      repeat (5) step('0, 1'b0);
      check("err_sticky", o_err, 1'b1);
      do_reset(1, 1'b1);
      step('0, 1'b0);
      check("err_cleared", o_err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
